// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mul_div_unit
// Description : Multi-cycle signed multiply / divide unit. The unit uses
//               radix-2 Booth for MUL and non-restoring division on operand
//               magnitudes for DIV. Results go to the Z_HI / Z_LO register
//               pair. The control unit talks to it through a
//               start / busy / done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] ra,
  input  logic [WIDTH-1:0] rb,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] z_hi,
  output logic [WIDTH-1:0] z_lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  // Two guard bits above WIDTH. They let the Booth accumulator absorb
  // -(most negative) and hold the non-restoring partial remainder (|P| < 2V).
  localparam int ACC_W = WIDTH + 2;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] acc;        // Booth A / partial remainder
  logic [ACC_W-1:0] m;          // multiplicand, or divisor magnitude
  logic [WIDTH-1:0] q;          // Booth Q / dividend-quotient shifter
  logic             q_m1;       // Booth q-1 bit
  logic [WIDTH-1:0] ra_hold;    // dividend echoed to z_hi on divide-by-zero
  logic             op_hold;
  logic             dz_pend;
  logic             quot_neg;
  logic             rem_neg;

  logic [WIDTH-1:0] ra_abs;
  logic [WIDTH-1:0] rb_abs;
  logic [ACC_W-1:0] booth_sum;
  logic [ACC_W-1:0] div_shift;
  logic [ACC_W-1:0] div_acc;
  logic [WIDTH-1:0] rem_mag;
  logic [WIDTH-1:0] quot_out;
  logic [WIDTH-1:0] rem_out;

  assign busy   = (state != IDLE);
  assign done   = (state == DONE);
  assign ra_abs = ra[WIDTH-1] ? -ra : ra;
  assign rb_abs = rb[WIDTH-1] ? -rb : rb;

  // Non-restoring step: shift in the next dividend bit, then add or subtract
  // the divisor depending on the sign of the current partial remainder.
  assign div_shift = {acc[ACC_W-2:0], q[WIDTH-1]};
  assign div_acc   = acc[ACC_W-1] ? (div_shift + m) : (div_shift - m);

  // A final remainder restore is needed when it ended negative. Only the low
  // bits matter because the true remainder is below the divisor.
  assign rem_mag  = acc[ACC_W-1] ? (acc[WIDTH-1:0] + m[WIDTH-1:0]) : acc[WIDTH-1:0];
  assign quot_out = quot_neg ? -q : q;
  assign rem_out  = rem_neg ? -rem_mag : rem_mag;

  // Booth recoding: add or subtract the multiplicand according to {Q0, q-1}.
  always_comb begin
    booth_sum = acc;
    case ({q[0], q_m1})
      2'b01:   booth_sum = acc + m;
      2'b10:   booth_sum = acc - m;
      default: booth_sum = acc;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic. A divide by zero skips RUN so that the result lands
  // one edge after acceptance.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (op && (rb == '0)) ? FIX : RUN;
      RUN:     if (cnt == LAST_ITER) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath. Latch operands on accept, iterate in RUN, publish results in FIX.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      cnt         <= '0;
      acc         <= '0;
      m           <= '0;
      q           <= '0;
      q_m1        <= 1'b0;
      ra_hold     <= '0;
      op_hold     <= 1'b0;
      dz_pend     <= 1'b0;
      quot_neg    <= 1'b0;
      rem_neg     <= 1'b0;
      div_by_zero <= 1'b0;
      z_hi        <= '0;
      z_lo        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt         <= '0;
            acc         <= '0;
            q_m1        <= 1'b0;
            ra_hold     <= ra;
            op_hold     <= op;
            dz_pend     <= op && (rb == '0);
            quot_neg    <= ra[WIDTH-1] ^ rb[WIDTH-1];
            rem_neg     <= ra[WIDTH-1];
            div_by_zero <= 1'b0;
            if (op) begin
              m <= {2'b00, rb_abs};
              q <= ra_abs;
            end else begin
              m <= {{2{ra[WIDTH-1]}}, ra};
              q <= rb;
            end
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (op_hold) begin
            acc <= div_acc;
            q   <= {q[WIDTH-2:0], ~div_acc[ACC_W-1]};
          end else begin
            acc  <= {booth_sum[ACC_W-1], booth_sum[ACC_W-1:1]};
            q    <= {booth_sum[0], q[WIDTH-1:1]};
            q_m1 <= q[0];
          end
        end
        FIX: begin
          if (dz_pend) begin
            z_hi        <= ra_hold;
            z_lo        <= '1;
            div_by_zero <= 1'b1;
          end else if (op_hold) begin
            z_hi <= rem_out;
            z_lo <= quot_out;
          end else begin
            z_hi <= acc[WIDTH-1:0];
            z_lo <= q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_div_unit
// Description : Self-checking bench for mul_div_unit. It checks against a
//               scoreboard of expected results computed from a 64-bit
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         clear;
  logic         start;
  logic         op;
  logic [W-1:0] ra;
  logic [W-1:0] rb;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] z_hi;
  logic [W-1:0] z_lo;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .clear       (clear),
    .start       (start),
    .op          (op),
    .ra          (ra),
    .rb          (rb),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .z_hi        (z_hi),
    .z_lo        (z_lo)
  );

  always #5 clk = ~clk;

  // Reference model: wide signed arithmetic, C truncation for divide.
  function automatic exp_t model(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint sa;
    longint sbv;
    longint r;
    longint qq;
    longint rr;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    if (!o) begin
      r    = sa * sbv;
      e.hi = r[63:32];
      e.lo = r[31:0];
      e.dz = 1'b0;
    end else if (b == '0) begin
      e.hi = a;
      e.lo = '1;
      e.dz = 1'b1;
    end else begin
      qq   = sa / sbv;
      rr   = sa % sbv;
      e.hi = rr[31:0];
      e.lo = qq[31:0];
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Wait for IDLE, present a request for one edge, and record its expectation.
  // On return the time is just after the accepting edge. The operands are
  // scrambled at that point.
  task automatic issue(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
    int k;
    k = 0;
    @(negedge clk);
    while (busy !== 1'b0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    op    = o;
    ra    = a;
    rb    = b;
    start = 1'b1;
    sb.push_back(model(o, a, b));
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = ~o;
    ra    = $urandom;
    rb    = $urandom;
  endtask

  // Count edges until done is seen, within a bound. Returns -1 on timeout.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset;
    clear = 1'b1;
    start = 1'b0;
    op    = 1'b0;
    ra    = '0;
    rb    = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({busy, done, div_by_zero, z_hi, z_lo} !== '0) begin
      bad++;
      $display("FAIL reset_state: got busy=%b done=%b dz=%b hi=%h lo=%h expected all zero",
               busy, done, div_by_zero, z_hi, z_lo);
    end
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic test_latency;
    int   lat;
    exp_t e;
    issue(1'b0, 32'd7, 32'hFFFF_FFFD);
    total++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL busy_after_accept: got busy=%b done=%b expected busy=1 done=0", busy, done);
    end
    wait_done(lat);
    total++;
    if (lat !== 33) begin
      bad++;
      $display("FAIL mul_latency: got %0d expected 33", lat);
    end
    e = sb.pop_front();
    total++;
    if ({z_hi, z_lo, div_by_zero} !== {e.hi, e.lo, e.dz}) begin
      bad++;
      $display("FAIL mul_7x-3: got hi=%h lo=%h dz=%b expected hi=%h lo=%h dz=%b",
               z_hi, z_lo, div_by_zero, e.hi, e.lo, e.dz);
    end
    @(posedge clk);
    #1;
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL done_pulse: got done=%b busy=%b expected done=0 busy=0", done, busy);
    end
  endtask

  task automatic test_mul;
    logic [W-1:0] av[6];
    logic [W-1:0] bv[6];
    int           lat;
    exp_t         e;
    av = '{32'h8000_0000, 32'h1234_5678, 32'hFFFF_FFFF, $urandom, $urandom, $urandom};
    bv = '{32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFFF, $urandom, $urandom, 32'h7FFF_FFFF};
    for (int i = 0; i < 6; i++) begin
      issue(1'b0, av[i], bv[i]);
      wait_done(lat);
      total++;
      if (lat !== 33) begin
        bad++;
        $display("FAIL mul_latency[%0d]: got %0d expected 33", i, lat);
      end
      e = sb.pop_front();
      total++;
      if ({z_hi, z_lo, div_by_zero} !== {e.hi, e.lo, e.dz}) begin
        bad++;
        $display("FAIL mul[%0d] %h*%h: got hi=%h lo=%h dz=%b expected hi=%h lo=%h dz=%b",
                 i, av[i], bv[i], z_hi, z_lo, div_by_zero, e.hi, e.lo, e.dz);
      end
    end
  endtask

  task automatic test_div;
    logic [W-1:0] av[7];
    logic [W-1:0] bv[7];
    int           lat;
    exp_t         e;
    av = '{32'hFFFF_FFEF, 32'd17, 32'h8000_0000, 32'd5, 32'h8000_0000, $urandom, $urandom};
    bv = '{32'd5, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'd17, 32'd7, $urandom | 32'h1, $urandom_range(1, 1000)};
    for (int i = 0; i < 7; i++) begin
      issue(1'b1, av[i], bv[i]);
      wait_done(lat);
      total++;
      if (lat !== 33) begin
        bad++;
        $display("FAIL div_latency[%0d]: got %0d expected 33", i, lat);
      end
      e = sb.pop_front();
      total++;
      if ({z_hi, z_lo, div_by_zero} !== {e.hi, e.lo, e.dz}) begin
        bad++;
        $display("FAIL div[%0d] %h/%h: got hi=%h lo=%h dz=%b expected hi=%h lo=%h dz=%b",
                 i, av[i], bv[i], z_hi, z_lo, div_by_zero, e.hi, e.lo, e.dz);
      end
    end
  endtask

  task automatic test_div0;
    int   lat;
    exp_t e;
    issue(1'b1, 32'd100, 32'd0);
    wait_done(lat);
    total++;
    if (lat !== 1) begin
      bad++;
      $display("FAIL div0_latency: got %0d expected 1", lat);
    end
    e = sb.pop_front();
    total++;
    if ({z_hi, z_lo, div_by_zero} !== {e.hi, e.lo, e.dz}) begin
      bad++;
      $display("FAIL div0_result: got hi=%h lo=%h dz=%b expected hi=%h lo=%h dz=%b",
               z_hi, z_lo, div_by_zero, e.hi, e.lo, e.dz);
    end
    issue(1'b1, 32'd50, 32'd7);
    total++;
    if (div_by_zero !== 1'b0) begin
      bad++;
      $display("FAIL dz_cleared_on_start: got %b expected 0", div_by_zero);
    end
    wait_done(lat);
    e = sb.pop_front();
    total++;
    if ({z_hi, z_lo, div_by_zero} !== {e.hi, e.lo, e.dz}) begin
      bad++;
      $display("FAIL div_after_div0: got hi=%h lo=%h dz=%b expected hi=%h lo=%h dz=%b",
               z_hi, z_lo, div_by_zero, e.hi, e.lo, e.dz);
    end
  endtask

  task automatic test_back_to_back;
    int           lat;
    exp_t         e;
    logic [W-1:0] prev_hi;
    logic [W-1:0] prev_lo;
    prev_hi = z_hi;
    prev_lo = z_lo;
    issue(1'b0, 32'h0000_BEEF, 32'hFFFF_1234);
    repeat (4) @(negedge clk);
    start = 1'b1;
    op    = 1'b1;
    ra    = 32'd99;
    rb    = 32'd0;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (z_hi !== prev_hi || z_lo !== prev_lo) begin
      bad++;
      $display("FAIL z_hold_mid_op: got hi=%h lo=%h expected hi=%h lo=%h", z_hi, z_lo, prev_hi, prev_lo);
    end
    wait_done(lat);
    total++;
    if (lat !== 29) begin
      bad++;
      $display("FAIL ignored_start_latency: got %0d expected 29", lat);
    end
    e = sb.pop_front();
    total++;
    if ({z_hi, z_lo, div_by_zero} !== {e.hi, e.lo, e.dz}) begin
      bad++;
      $display("FAIL ignored_start_result: got hi=%h lo=%h dz=%b expected hi=%h lo=%h dz=%b",
               z_hi, z_lo, div_by_zero, e.hi, e.lo, e.dz);
    end
    start = 1'b1;
    op    = 1'b0;
    ra    = 32'd3;
    rb    = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL start_in_done_ignored: got busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_abort;
    int   lat;
    exp_t e;
    logic saw;
    @(negedge clk);
    op    = 1'b0;
    ra    = 32'h0102_0304;
    rb    = 32'h0506_0708;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    clear = 1'b1;
    #1;
    total++;
    if ({busy, done, div_by_zero, z_hi, z_lo} !== '0) begin
      bad++;
      $display("FAIL abort_clear: got busy=%b done=%b dz=%b hi=%h lo=%h expected all zero",
               busy, done, div_by_zero, z_hi, z_lo);
    end
    @(negedge clk);
    clear = 1'b0;
    saw   = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) saw = 1'b1;
    end
    total++;
    if (saw !== 1'b0) begin
      bad++;
      $display("FAIL no_done_after_abort: got activity=%b expected 0", saw);
    end
    issue(1'b1, 32'hFFFF_FF9C, 32'd7);
    wait_done(lat);
    total++;
    if (lat !== 33) begin
      bad++;
      $display("FAIL fresh_latency: got %0d expected 33", lat);
    end
    e = sb.pop_front();
    total++;
    if ({z_hi, z_lo, div_by_zero} !== {e.hi, e.lo, e.dz}) begin
      bad++;
      $display("FAIL fresh_after_abort: got hi=%h lo=%h dz=%b expected hi=%h lo=%h dz=%b",
               z_hi, z_lo, div_by_zero, e.hi, e.lo, e.dz);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_mul();
    test_div();
    test_div0();
    test_back_to_back();
    test_abort();
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
